ex_mem_reg: RTL and testbench

Pipeline register between the execute stage and the data-memory stage of the MIPS core. It captures one EX result beat per cycle (ALU result, store data, destination register, memory control flags, PC). It adds a valid/ready handshake with a one-entry skid buffer, so a memory-side stall never creates a combinational ready path back into EX. It also supports a synchronous flush for branch and jump squashing.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mem_align_check.sv | 15 +
 rtl/ex_mem_reg.sv | 131 +++++++++++++
 tb/tb_ex_mem_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core constants: memory access encodings and EX/MEM payload packing width.
package mips_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF  = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD  = 2'b11;
  localparam logic       MEM_TYPE_LOAD  = 1'b0;
  localparam logic       MEM_TYPE_STORE = 1'b1;

  // rd(5) + reg_write + mem_op + mem_type + mem_size(2) + unsign
  localparam int EX_MEM_CTRL_W = 11;

  function automatic int ex_mem_payload_w(input int nbits);
    return 3 * nbits + EX_MEM_CTRL_W;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check for a data-memory access; zero latency, no flow control.
module mem_align_check
  import mips_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  input  logic       mem_op,
  output logic       misaligned
);

  // Reserved size 10 falls under size[1] and is checked as a word.
  assign misaligned = mem_op & (((size == MEM_SIZE_HALF) & addr[0]) |
                                (size[1] & (addr != 2'b00)));

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with one-entry skid buffer; 1-cycle latency, o_ready depends only on state.
// Optional EX_MEM_ALIGN_CHECK_EN flags misaligned accesses and suppresses their mem_op/reg_write.
module ex_mem_reg
  import mips_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [NBITS-1:0] i_pc,
  input  logic [NBITS-1:0] i_alu_result,
  input  logic [NBITS-1:0] i_store_data,
  input  logic [4:0]       i_rd,
  input  logic             i_flg_reg_write,
  input  logic             i_flg_mem_op,
  input  logic             i_flg_mem_type,
  input  logic [1:0]       i_flg_mem_size,
  input  logic             i_flg_unsign,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_alu_result,
  output logic [NBITS-1:0] o_store_data,
  output logic [4:0]       o_rd,
  output logic             o_flg_reg_write,
  output logic             o_flg_mem_op,
  output logic             o_flg_mem_type,
  output logic [1:0]       o_flg_mem_size,
  output logic             o_flg_unsign
`ifdef EX_MEM_ALIGN_CHECK_EN
  ,
  output logic             o_misaligned
`endif
);

  localparam int PW = ex_mem_payload_w(NBITS);

  logic [PW-1:0] in_dat;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_vld;
  logic          skid_vld;
  logic          accept;
  logic          release_beat;
  logic          ld_main_from_skid;
  logic          ld_main_from_in;
  logic          ld_skid;

`ifdef EX_MEM_ALIGN_CHECK_EN
  logic in_mis;
  logic main_mis;
  logic skid_mis;

  mem_align_check u_align (
    .addr       (i_alu_result[1:0]),
    .size       (i_flg_mem_size),
    .mem_op     (i_flg_mem_op),
    .misaligned (in_mis)
  );

  // A misaligned beat travels on as a bubble for memory and the register file.
  assign in_dat = {i_pc, i_alu_result, i_store_data, i_rd,
                   i_flg_reg_write & ~in_mis, i_flg_mem_op & ~in_mis,
                   i_flg_mem_type, i_flg_mem_size, i_flg_unsign};
`else
  assign in_dat = {i_pc, i_alu_result, i_store_data, i_rd,
                   i_flg_reg_write, i_flg_mem_op,
                   i_flg_mem_type, i_flg_mem_size, i_flg_unsign};
`endif

  assign o_ready      = i_rst & ~skid_vld;
  assign o_valid      = main_vld;
  assign accept       = i_valid & o_ready;
  assign release_beat = main_vld & i_ready;

  always_comb begin
    ld_main_from_skid = 1'b0;
    ld_main_from_in   = 1'b0;
    ld_skid           = 1'b0;
    if (!i_flush) begin
      ld_main_from_skid = skid_vld & release_beat;
      ld_main_from_in   = ~skid_vld & accept & (~main_vld | release_beat);
      ld_skid           = ~skid_vld & accept & main_vld & ~release_beat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (ld_main_from_skid || ld_main_from_in) main_vld <= 1'b1;
      else if (release_beat)                   main_vld <= 1'b0;
      if (ld_main_from_skid) skid_vld <= 1'b0;
      else if (ld_skid)      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_from_skid)    main_q <= skid_q;
      else if (ld_main_from_in) main_q <= in_dat;
      if (ld_skid)              skid_q <= in_dat;
    end
  end

`ifdef EX_MEM_ALIGN_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      main_mis <= 1'b0;
      skid_mis <= 1'b0;
    end else begin
      if (ld_main_from_skid)    main_mis <= skid_mis;
      else if (ld_main_from_in) main_mis <= in_mis;
      if (ld_skid)              skid_mis <= in_mis;
    end
  end

  assign o_misaligned = main_mis;
`endif

  assign {o_pc, o_alu_result, o_store_data, o_rd, o_flg_reg_write, o_flg_mem_op,
          o_flg_mem_type, o_flg_mem_size, o_flg_unsign} = main_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed and randomized self-checking bench for ex_mem_reg (covers EX_MEM_ALIGN_CHECK_EN when defined).
module tb_ex_mem_reg;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid;
  logic [31:0] i_pc, i_alu_result, i_store_data;
  logic [31:0] o_pc, o_alu_result, o_store_data;
  logic [4:0]  i_rd, o_rd;
  logic        i_flg_reg_write, i_flg_mem_op, i_flg_mem_type, i_flg_unsign;
  logic        o_flg_reg_write, o_flg_mem_op, o_flg_mem_type, o_flg_unsign;
  logic [1:0]  i_flg_mem_size, o_flg_mem_size;
`ifdef EX_MEM_ALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  ex_mem_reg #(.NBITS(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_rd(i_rd),
    .i_flg_reg_write(i_flg_reg_write), .i_flg_mem_op(i_flg_mem_op),
    .i_flg_mem_type(i_flg_mem_type), .i_flg_mem_size(i_flg_mem_size),
    .i_flg_unsign(i_flg_unsign),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_alu_result(o_alu_result), .o_store_data(o_store_data), .o_rd(o_rd),
    .o_flg_reg_write(o_flg_reg_write), .o_flg_mem_op(o_flg_mem_op),
    .o_flg_mem_type(o_flg_mem_type), .o_flg_mem_size(o_flg_mem_size),
    .o_flg_unsign(o_flg_unsign)
`ifdef EX_MEM_ALIGN_CHECK_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Plain ALU beat whose side fields derive from the address, so checks can rebuild them.
  task automatic set_beat(input logic [31:0] alu);
    i_alu_result    = alu;
    i_pc            = alu + 32'h400;
    i_store_data    = ~alu;
    i_rd            = alu[6:2];
    i_flg_reg_write = 1'b1;
    i_flg_mem_op    = 1'b0;
    i_flg_mem_type  = 1'b0;
    i_flg_mem_size  = 2'b11;
    i_flg_unsign    = 1'b0;
  endtask

  logic [31:0] sb_q[$];
  logic [31:0] seq;
  logic        hold;
  logic        acc, rel;

  initial begin
    i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    set_beat(32'h0);

    // Reset state
    tick();
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_alu", o_alu_result, 0);
    check("rst_pc", o_pc, 0);
    i_rst = 1'b1;
    #1;
    check("rst_release_ready", o_ready, 1);
    tick();
    check("idle_valid", o_valid, 0);

    // Streaming at full rate
    for (int k = 0; k < 4; k++) begin
      set_beat(32'h10 + 32'(4 * k));
      i_valid = 1'b1;
      tick();
      check("stream_valid", o_valid, 1);
      check("stream_alu", o_alu_result, 32'h10 + 32'(4 * k));
      check("stream_ready", o_ready, 1);
    end
    check("stream_pc", o_pc, 32'h41C);
    check("stream_sdata", o_store_data, 32'hFFFF_FFE3);
    check("stream_rd", o_rd, 5'd7);
    i_valid = 1'b0;
    tick();
    check("stream_drain", o_valid, 0);

    // Stall for three cycles under continuous valid
    i_ready = 1'b0; i_valid = 1'b1;
    set_beat(32'h20);
    tick();
    check("stall_a_alu", o_alu_result, 32'h20);
    check("stall_a_ready", o_ready, 1);
    set_beat(32'h24);
    tick();
    check("stall_skid_ready", o_ready, 0);
    check("stall_hold_alu", o_alu_result, 32'h20);
    set_beat(32'h28);
    tick();
    check("stall_still_ready", o_ready, 0);
    check("stall_still_alu", o_alu_result, 32'h20);
    i_ready = 1'b1;
    tick();
    check("unstall_b_alu", o_alu_result, 32'h24);
    check("unstall_ready", o_ready, 1);
    tick();
    check("unstall_c_alu", o_alu_result, 32'h28);
    check("unstall_c_valid", o_valid, 1);
    i_valid = 1'b0;
    tick();
    check("unstall_drain", o_valid, 0);

    // Flush with both slots full
    i_ready = 1'b0; i_valid = 1'b1;
    set_beat(32'h30); tick();
    set_beat(32'h34); tick();
    check("flush_pre_ready", o_ready, 0);
    set_beat(32'h38); i_flush = 1'b1;
    tick();
    check("flush_valid", o_valid, 0);
    check("flush_ready", o_ready, 1);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    tick();
    check("flush_no_ghost", o_valid, 0);

    // Flush drops a beat accepted in the same cycle
    i_ready = 1'b0; i_valid = 1'b1;
    set_beat(32'h3C); tick();
    set_beat(32'h40); i_flush = 1'b1;
    #1;
    check("flush_acc_ready", o_ready, 1);
    tick();
    check("flush_acc_valid", o_valid, 0);
    i_flush = 1'b0; i_valid = 1'b0;
    tick();
    check("flush_acc_gone", o_valid, 0);

    // Store flags with reserved size pass through
    i_ready = 1'b1; i_valid = 1'b1;
    set_beat(32'h50);
    i_flg_reg_write = 1'b0; i_flg_mem_op = 1'b1; i_flg_mem_type = 1'b1;
    i_flg_mem_size = 2'b10; i_flg_unsign = 1'b1;
    tick();
    check("flags_pack", {o_flg_reg_write, o_flg_mem_op, o_flg_mem_type, o_flg_mem_size, o_flg_unsign},
          6'b011101);
    i_valid = 1'b0;
    tick();

    // Reset while the skid slot is full
    i_ready = 1'b0; i_valid = 1'b1;
    set_beat(32'h60); tick();
    set_beat(32'h64); tick();
    check("rstmid_pre_ready", o_ready, 0);
    i_rst = 1'b0; i_valid = 1'b0;
    tick();
    check("rstmid_valid", o_valid, 0);
    check("rstmid_ready", o_ready, 0);
    check("rstmid_payload", {o_alu_result, o_pc}, 64'h0);
    check("rstmid_rd", o_rd, 0);
    tick();
    check("rstmid_ready_low", o_ready, 0);
    i_rst = 1'b1; i_ready = 1'b1;
    #1;
    check("rstmid_ready_up", o_ready, 1);
    tick();
    check("rstmid_empty", o_valid, 0);

`ifdef EX_MEM_ALIGN_CHECK_EN
    // Misaligned word store is squashed into a flagged bubble
    i_valid = 1'b1;
    set_beat(32'h1002);
    i_flg_mem_op = 1'b1; i_flg_mem_type = 1'b1; i_flg_mem_size = 2'b11;
    tick();
    check("align_word_mis", o_misaligned, 1);
    check("align_word_memop", o_flg_mem_op, 0);
    check("align_word_regw", o_flg_reg_write, 0);
    set_beat(32'h1002);
    i_flg_mem_op = 1'b1; i_flg_mem_type = 1'b0; i_flg_mem_size = 2'b01;
    tick();
    check("align_half_mis", o_misaligned, 0);
    check("align_half_memop", o_flg_mem_op, 1);
    check("align_half_regw", o_flg_reg_write, 1);
    i_valid = 1'b0;
    tick();
`endif

    // Random valid/ready/flush against a FIFO scoreboard
    seq = 32'h1000_0000;
    hold = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (n >= 9990) begin
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      end else begin
        if (!hold) begin
          i_valid = ($urandom_range(0, 3) != 0);
          set_beat(seq);
        end
        i_ready = ($urandom_range(0, 2) != 0);
        i_flush = ($urandom_range(0, 39) == 0);
      end
      #1;
      acc = i_valid & o_ready;
      rel = o_valid & i_ready;
      if (rel) begin
        if (sb_q.size() == 0) check("sb_unexpected", o_valid, 0);
        else check("sb_data", o_alu_result, sb_q.pop_front());
      end
      if (i_flush) sb_q.delete();
      else if (acc) sb_q.push_back(i_alu_result);
      if (acc) seq = seq + 1;
      hold = i_valid & ~o_ready & ~i_flush;
      tick();
    end
    check("sb_leftover", sb_q.size(), 0);
    check("sb_final_valid", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
